// File: rtl/binary_morphology_pkg.sv
// -----------------------------------------------------------------------------
// binary_morphology_pkg
//   Shared definitions for the binary morphology engine: operation select
//   encodings, FSM state encoding and the flush-length helper.
// -----------------------------------------------------------------------------
package binary_morphology_pkg;

    localparam logic MODE_ERODE  = 1'b0;
    localparam logic MODE_DILATE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Number of extra window advances needed after the last input pixel so
    // that the kernel centre reaches the final pixel of the frame: R*W + R.
    function automatic int flush_len(input int kernel_size, input int img_width);
        return ((kernel_size - 1) / 2) * img_width + (kernel_size - 1) / 2;
    endfunction

endpackage

// File: rtl/binary_morphology_if.sv
// -----------------------------------------------------------------------------
// binary_morphology_if
//   Pixel stream bundle for the morphology engine.
//   Handshake: an input beat transfers on a clock edge where pixel_in_valid and
//   pixel_in_ready are both high; pixel_in must be held stable while valid is
//   high and ready is low. The output side has no backpressure: pixel_out is
//   meaningful for exactly the cycles where pixel_out_valid is high, and
//   frame_done pulses together with the last pixel of a frame.
//   master : upstream/testbench side      slave : engine side
// -----------------------------------------------------------------------------
interface binary_morphology_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] pixel_in;
    logic                  pixel_in_valid;
    logic                  pixel_in_ready;
    logic [DATA_WIDTH-1:0] pixel_out;
    logic                  pixel_out_valid;
    logic                  frame_done;

    modport master (
        output pixel_in, pixel_in_valid,
        input  pixel_in_ready, pixel_out, pixel_out_valid, frame_done
    );

    modport slave (
        input  pixel_in, pixel_in_valid,
        output pixel_in_ready, pixel_out, pixel_out_valid, frame_done
    );
endinterface

// File: rtl/binary_morphology_line_buffer_n.sv
// -----------------------------------------------------------------------------
// binary_morphology_line_buffer_n
//   Chain of TAPS line delays, each LINE_WORDS deep, sharing one circular
//   pointer. dout[0] is din delayed by one line, dout[t] by t+1 lines.
//   Reads are asynchronous so the taps are usable on the same edge that
//   writes the new word (distributed RAM / SRL style storage).
//   Ports: clk, rst (async, clears the pointer only), en (advance one word),
//          din, dout[TAPS].
// -----------------------------------------------------------------------------
module binary_morphology_line_buffer_n #(
    parameter int WIDTH      = 1,
    parameter int LINE_WORDS = 10,
    parameter int TAPS       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout [TAPS]
);
    localparam int PW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic [WIDTH-1:0] mem [TAPS][LINE_WORDS];
    logic [PW-1:0]    ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PW'(LINE_WORDS - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Storage is left unreset; stale words only ever reach border pixels.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0][ptr] <= din;
            for (int t = 1; t < TAPS; t++) begin
                mem[t][ptr] <= mem[t-1][ptr];
            end
        end
    end

    always_comb begin
        for (int t = 0; t < TAPS; t++) begin
            dout[t] = mem[t][ptr];
        end
    end

endmodule

// File: rtl/binary_morphology.sv
// -----------------------------------------------------------------------------
// binary_morphology
//   Streaming KxK binary erosion/dilation with programmable binarisation
//   threshold and a built-in end-of-frame flush, so each frame of
//   IMG_WIDTH*IMG_HEIGHT input pixels yields exactly as many output pixels.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     mode           0 = erode, 1 = dilate (latched on a frame's first accept)
//     threshold      bit = pixel_in >= threshold (latched with mode)
//     bus            pixel stream (slave side of binary_morphology_if)
//     state_dbg      current FSM state
//   Pipeline: advance (window) -> reduce/border (s2) -> output register, so an
//   output appears 3 cycles after the advance that completed its window.
// -----------------------------------------------------------------------------
module binary_morphology
    import binary_morphology_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMG_WIDTH    = 10,
    parameter int IMG_HEIGHT   = 4,
    parameter int KERNEL_SIZE  = 3,
    parameter int BORDER_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] threshold,
    binary_morphology_if.slave    bus,
    output state_t                state_dbg
);
    localparam int   K          = KERNEL_SIZE;
    localparam int   R          = (K - 1) / 2;
    localparam int   FLUSH_LEN  = flush_len(K, IMG_WIDTH);
    localparam int   XW         = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int   YW         = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int   FW         = $clog2(FLUSH_LEN + 1);
    localparam logic BORDER_BIT = (BORDER_VALUE != 0);

    state_t                state, state_nxt;
    logic [XW-1:0]         in_x, out_x, s1_x;
    logic [YW-1:0]         in_y, out_y, s1_y;
    logic [FW-1:0]         flush_cnt, fill_cnt;
    logic                  mode_q;
    logic [DATA_WIDTH-1:0] thr_q, thr_eff;
    logic                  accept, strobe, advance, emit, last_in;
    logic                  in_bit;
    logic [0:0]            lb_dout [K-1];
    logic [K-1:0]          col;
    logic [K-1:0]          win [K];
    logic                  all_ones, any_one, border1;
    logic                  s1_valid, s2_valid, s2_bit, s2_last;

    // ---------------- control ----------------
    assign bus.pixel_in_ready = (state != ST_FLUSH);
    assign accept    = bus.pixel_in_valid && bus.pixel_in_ready;
    assign strobe    = (state == ST_FLUSH);
    assign advance   = accept || strobe;
    assign emit      = advance && (fill_cnt == FW'(FLUSH_LEN));
    assign last_in   = (in_x == XW'(IMG_WIDTH - 1)) && (in_y == YW'(IMG_HEIGHT - 1));
    assign state_dbg = state;

    // The first beat of a frame uses the live threshold since it is the beat
    // that latches it.
    assign thr_eff = (state == ST_IDLE) ? threshold : thr_q;
    assign in_bit  = strobe ? 1'b0 : (bus.pixel_in >= thr_eff);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_RUN;
            ST_RUN:   if (accept && last_in) state_nxt = ST_FLUSH;
            ST_FLUSH: if (flush_cnt == FW'(FLUSH_LEN - 1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_x      <= '0;
            in_y      <= '0;
            flush_cnt <= '0;
            fill_cnt  <= '0;
            mode_q    <= MODE_ERODE;
            thr_q     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (in_x == XW'(IMG_WIDTH - 1)) begin
                    in_x <= '0;
                    in_y <= (in_y == YW'(IMG_HEIGHT - 1)) ? '0 : in_y + 1'b1;
                end else begin
                    in_x <= in_x + 1'b1;
                end
            end
            if (accept && state == ST_IDLE) begin
                mode_q <= mode;
                thr_q  <= threshold;
            end
            flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 1'b1 : '0;
            // fill_cnt saturates at FLUSH_LEN once the window has primed and
            // is rearmed when the flush completes.
            if (state == ST_FLUSH && state_nxt == ST_IDLE) begin
                fill_cnt <= '0;
            end else if (advance && fill_cnt != FW'(FLUSH_LEN)) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // ---------------- window ----------------
    binary_morphology_line_buffer_n #(
        .WIDTH      (1),
        .LINE_WORDS (IMG_WIDTH),
        .TAPS       (K - 1)
    ) u_lines (
        .clk  (clk),
        .rst  (rst),
        .en   (advance),
        .din  (in_bit),
        .dout (lb_dout)
    );

    // Row K-1 is the current line, row K-2-t comes from line tap t.
    always_comb begin
        col        = '0;
        col[K-1]   = in_bit;
        for (int t = 0; t < K - 1; t++) begin
            col[K-2-t] = lb_dout[t][0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                win[r] <= '0;
            end
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            out_x    <= '0;
            out_y    <= '0;
        end else begin
            if (advance) begin
                for (int r = 0; r < K; r++) begin
                    win[r] <= {win[r][K-2:0], col[r]};
                end
            end
            s1_valid <= emit;
            if (emit) begin
                s1_x <= out_x;
                s1_y <= out_y;
                if (out_x == XW'(IMG_WIDTH - 1)) begin
                    out_x <= '0;
                    out_y <= (out_y == YW'(IMG_HEIGHT - 1)) ? '0 : out_y + 1'b1;
                end else begin
                    out_x <= out_x + 1'b1;
                end
            end
        end
    end

    // ---------------- reduce, mask, output ----------------
    always_comb begin
        all_ones = 1'b1;
        any_one  = 1'b0;
        for (int r = 0; r < K; r++) begin
            all_ones = all_ones & (&win[r]);
            any_one  = any_one | (|win[r]);
        end
    end

    // Windows at the frame edge straddle line wrap or stale data; masking
    // them here keeps the interior result independent of that content.
    assign border1 = (int'(s1_x) < R) || (int'(s1_x) >= IMG_WIDTH - R) ||
                     (int'(s1_y) < R) || (int'(s1_y) >= IMG_HEIGHT - R);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid            <= 1'b0;
            s2_bit              <= 1'b0;
            s2_last             <= 1'b0;
            bus.pixel_out       <= '0;
            bus.pixel_out_valid <= 1'b0;
            bus.frame_done      <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_bit   <= border1 ? BORDER_BIT :
                        (mode_q == MODE_DILATE) ? any_one : all_ones;
            s2_last  <= s1_valid && (s1_x == XW'(IMG_WIDTH - 1)) &&
                        (s1_y == YW'(IMG_HEIGHT - 1));
            bus.pixel_out       <= (s2_valid && s2_bit) ? '1 : '0;
            bus.pixel_out_valid <= s2_valid;
            bus.frame_done      <= s2_valid && s2_last;
        end
    end

endmodule

// File: tb/tb_binary_morphology.sv
// -----------------------------------------------------------------------------
// tb_binary_morphology
//   Three engines on one clock (K=3/border 0, K=3/border 1, K=5/border 0),
//   all 8x6. One is selected at a time; a table of frame records drives it and
//   a reference model fills the expected queue for every output pixel.
// -----------------------------------------------------------------------------
module tb_binary_morphology;
    import binary_morphology_pkg::*;

    localparam int TW = 8;
    localparam int TH = 6;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [7:0] threshold;
    logic [7:0] pixel_in;
    logic       valid;
    int         sel;
    bit         ignore_out;

    state_t st_a, st_b, st_c;

    binary_morphology_if #(.DATA_WIDTH(8)) if_a ();
    binary_morphology_if #(.DATA_WIDTH(8)) if_b ();
    binary_morphology_if #(.DATA_WIDTH(8)) if_c ();

    assign if_a.pixel_in = pixel_in;
    assign if_b.pixel_in = pixel_in;
    assign if_c.pixel_in = pixel_in;
    assign if_a.pixel_in_valid = valid && (sel == 0);
    assign if_b.pixel_in_valid = valid && (sel == 1);
    assign if_c.pixel_in_valid = valid && (sel == 2);

    binary_morphology #(.DATA_WIDTH(8), .IMG_WIDTH(TW), .IMG_HEIGHT(TH),
                        .KERNEL_SIZE(3), .BORDER_VALUE(0)) u_dut_a (
        .clk(clk), .rst(rst), .mode(mode), .threshold(threshold),
        .bus(if_a), .state_dbg(st_a));
    binary_morphology #(.DATA_WIDTH(8), .IMG_WIDTH(TW), .IMG_HEIGHT(TH),
                        .KERNEL_SIZE(3), .BORDER_VALUE(1)) u_dut_b (
        .clk(clk), .rst(rst), .mode(mode), .threshold(threshold),
        .bus(if_b), .state_dbg(st_b));
    binary_morphology #(.DATA_WIDTH(8), .IMG_WIDTH(TW), .IMG_HEIGHT(TH),
                        .KERNEL_SIZE(5), .BORDER_VALUE(0)) u_dut_c (
        .clk(clk), .rst(rst), .mode(mode), .threshold(threshold),
        .bus(if_c), .state_dbg(st_c));

    logic       cur_ready, mon_valid, mon_done;
    logic [7:0] mon_pix;
    always_comb begin
        cur_ready = if_a.pixel_in_ready;
        mon_valid = if_a.pixel_out_valid;
        mon_done  = if_a.frame_done;
        mon_pix   = if_a.pixel_out;
        if (sel == 1) begin
            cur_ready = if_b.pixel_in_ready;
            mon_valid = if_b.pixel_out_valid;
            mon_done  = if_b.frame_done;
            mon_pix   = if_b.pixel_out;
        end else if (sel == 2) begin
            cur_ready = if_c.pixel_in_ready;
            mon_valid = if_c.pixel_out_valid;
            mon_done  = if_c.frame_done;
            mon_pix   = if_c.pixel_out;
        end
    end

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int         checks;
    int         errors;
    int         ones_cnt;
    logic [8:0] exp_q[$];      // {frame_done, pixel_out}
    int         exp_ones_q[$];
    logic [7:0] img [TH][TW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_frame(input int k, input bit border, input bit md, input logic [7:0] thr);
        int  r;
        bit  v;
        bit  last;
        r = (k - 1) / 2;
        for (int y = 0; y < TH; y++) begin
            for (int x = 0; x < TW; x++) begin
                if (x < r || x >= TW - r || y < r || y >= TH - r) begin
                    v = border;
                end else begin
                    v = !md;
                    for (int dy = -r; dy <= r; dy++) begin
                        for (int dx = -r; dx <= r; dx++) begin
                            if (md) v = v | (img[y+dy][x+dx] >= thr);
                            else    v = v & (img[y+dy][x+dx] >= thr);
                        end
                    end
                end
                last = (x == TW - 1) && (y == TH - 1);
                exp_q.push_back({last, v ? 8'hFF : 8'h00});
            end
        end
    endtask

    task automatic monitor_loop();
        logic [8:0] e;
        int         eo;
        forever begin
            @(negedge clk);
            if (!rst && !ignore_out) begin
                if (mon_valid) begin
                    if (exp_q.size() == 0) begin
                        check("out_unexpected", {mon_done, mon_pix}, 9'h000);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", {mon_done, mon_pix}, e);
                    end
                    if (mon_pix == 8'hFF) ones_cnt++;
                    if (mon_done) begin
                        eo = (exp_ones_q.size() != 0) ? exp_ones_q.pop_front() : -1;
                        check("frame_ones", ones_cnt, eo);
                        ones_cnt = 0;
                    end
                end else if (mon_done) begin
                    check("done_without_valid", 1, 0);
                end
            end
        end
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        int         sel;
        bit         md;
        logic [7:0] thr;
        logic [7:0] fill;
        int         sx;
        int         sy;
        logic [7:0] sv;
        int         gap;
        bit         scramble;
        int         exp_ones;
        int         exp_flush;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input int s, input bit md, input int thr, input int fill,
                                input int sx, input int sy, input int sv, input int gap,
                                input bit scr, input int ones, input int fl);
        vec_t v;
        v.sel = s; v.md = md; v.thr = 8'(thr); v.fill = 8'(fill);
        v.sx = sx; v.sy = sy; v.sv = 8'(sv); v.gap = gap; v.scramble = scr;
        v.exp_ones = ones; v.exp_flush = fl;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_frame(input vec_t v, input int stop_after);
        int n;
        int guard;
        int lowc;
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++)
                img[y][x] = (x == v.sx && y == v.sy) ? v.sv : v.fill;
        if (stop_after == 0) begin
            model_frame((v.sel == 2) ? 5 : 3, v.sel == 1, v.md, v.thr);
            exp_ones_q.push_back(v.exp_ones);
        end
        mode      = v.md;
        threshold = v.thr;
        n = (stop_after == 0) ? TW * TH : stop_after;
        for (int i = 0; i < n; i++) begin
            while (v.gap > 0 && $urandom_range(99) < v.gap) begin
                valid = 1'b0;
                @(posedge clk); #1;
            end
            pixel_in = img[i / TW][i % TW];
            valid    = 1'b1;
            guard    = 0;
            while (!cur_ready && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 200) begin
                check("ready_timeout", 0, 1);
                valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (i == 0 && v.scramble) begin
                mode      = ~v.md;
                threshold = 8'hFF;
            end
        end
        valid = 1'b0;
        if (stop_after == 0) begin
            lowc = 0;
            while (!cur_ready && lowc < 100) begin
                lowc++;
                @(posedge clk); #1;
            end
            check("flush_ready_low", lowc, v.exp_flush);
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || exp_ones_q.size() != 0) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain", guard < 500, 1);
    endtask

    // ---------------- test ----------------
    initial begin
        checks = 0; errors = 0; ones_cnt = 0;
        rst = 1'b1; valid = 1'b0; sel = 0; mode = 1'b0; threshold = 8'd0;
        pixel_in = 8'd0; ignore_out = 1'b0;

        //           sel md thr  fill sx sy sv  gap scr ones flush
        tbl[0]  = mk(0, 0, 128, 200, 0, 0, 200, 0, 0, 24,  9);
        tbl[1]  = mk(0, 0, 128, 200, 3, 2,   0, 0, 0, 15,  9);
        tbl[2]  = mk(0, 1, 128,   0, 4, 3, 255, 0, 0,  9,  9);
        tbl[3]  = mk(0, 0, 128, 200, 0, 0, 200, 50, 0, 24, 9);
        tbl[4]  = mk(0, 1, 128,   0, 4, 3, 255, 50, 0,  9, 9);
        tbl[5]  = mk(0, 0, 100, 200, 3, 2,  50, 0, 1, 15,  9);
        tbl[6]  = mk(0, 1,  60,  50, 1, 1,  60, 0, 0,  4,  9);
        tbl[7]  = mk(0, 0, 201, 200, 0, 0, 200, 0, 0,  0,  9);
        tbl[8]  = mk(1, 1, 128,   0, 4, 3, 255, 0, 0, 33,  9);
        tbl[9]  = mk(2, 0, 128, 255, 0, 0, 255, 0, 0,  8, 18);
        tbl[10] = mk(2, 1, 128,   0, 0, 0, 255, 0, 0,  1, 18);

        fork
            monitor_loop();
        join_none

        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", if_a.pixel_out_valid, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", if_a.pixel_in_ready, 1);
        check("reset_pixel_out", if_a.pixel_out, 0);
        check("reset_frame_done", if_a.frame_done, 0);
        check("reset_state", st_a, ST_IDLE);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].sel != sel) begin
                wait_drain();
                sel = tbl[i].sel;
            end
            drive_frame(tbl[i], 0);
        end
        wait_drain();
        sel = 0;

        // Reset in the middle of a frame, then a full frame from scratch.
        ignore_out = 1'b1;
        drive_frame(tbl[1], 20);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_out_valid", if_a.pixel_out_valid, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_state", st_a, ST_IDLE);
        ignore_out = 1'b0;
        drive_frame(tbl[1], 0);
        wait_drain();
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
